// File: rtl/fpa_align_shift.sv
// Operand swap and significand alignment stage of the FP adder: routes the larger operand to
// the large path and right-shifts the smaller one bit-serially. Optional macro: FPA_ALIGN_STICKY_EN.
module fpa_align_shift #(
    parameter int unsigned width = 32,
    parameter int unsigned exp_w = 8,
    parameter int unsigned man_w = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    input  logic                 a_gt_eq_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign_l,
    output logic                 eff_sub,
    output logic [exp_w-1:0]     exp_l,
    output logic [man_w+3:0]     man_l,
    output logic [man_w+3:0]     man_s
);

    localparam int unsigned SIG_W = man_w + 4;
    localparam int unsigned CNT_W = $clog2(SIG_W + 1);

`ifdef FPA_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_d, sign_l_d, eff_sub_d;
    logic [exp_w-1:0]   exp_l_d;
    logic [SIG_W-1:0]   man_l_d, man_s_d;

    // Operand routing and effective exponents (denormals use exponent 1)
    logic [exp_w-1:0]   raw_exp_l, raw_exp_s, eexp_l, eexp_s, diff;
    logic [man_w-1:0]   frac_l, frac_s;
    logic               hid_l, hid_s, accept;
    logic [SIG_W-1:0]   sig_s, shifted;

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    always_comb begin
        raw_exp_l = a_gt_eq_b ? a[width-2 -: exp_w] : b[width-2 -: exp_w];
        raw_exp_s = a_gt_eq_b ? b[width-2 -: exp_w] : a[width-2 -: exp_w];
        frac_l    = a_gt_eq_b ? a[man_w-1:0] : b[man_w-1:0];
        frac_s    = a_gt_eq_b ? b[man_w-1:0] : a[man_w-1:0];
        hid_l     = |raw_exp_l;
        hid_s     = |raw_exp_s;
        eexp_l    = hid_l ? raw_exp_l : exp_w'(1);
        eexp_s    = hid_s ? raw_exp_s : exp_w'(1);
        diff      = eexp_l - eexp_s;
        sig_s     = {hid_s, frac_s, 3'b000};
        shifted   = {1'b0, man_s[SIG_W-1:1]};
        // Without sticky, bits falling off the bottom are simply truncated
        shifted[0] = man_s[1] | (STICKY & man_s[0]);
    end

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_l_d  = sign_l;
        eff_sub_d = eff_sub;
        exp_l_d   = exp_l;
        man_l_d   = man_l;
        man_s_d   = man_s;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_l_d  = a_gt_eq_b ? a[width-1] : b[width-1];
                    eff_sub_d = a[width-1] ^ b[width-1];
                    exp_l_d   = eexp_l;
                    man_l_d   = {hid_l, frac_l, 3'b000};
                    man_s_d   = sig_s;
                    if (diff == '0) begin
                        state_d = DONE;
                    end else if (32'(diff) >= SIG_W) begin
                        man_s_d = STICKY ? SIG_W'(|sig_s) : '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(diff);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                man_s_d = shifted;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            sign_l    <= 1'b0;
            eff_sub   <= 1'b0;
            exp_l     <= '0;
            man_l     <= '0;
            man_s     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            sign_l    <= sign_l_d;
            eff_sub   <= eff_sub_d;
            exp_l     <= exp_l_d;
            man_l     <= man_l_d;
            man_s     <= man_s_d;
        end
    end

endmodule
